// File: rtl/atm_txn_arbiter_if.sv
// atm_txn_arbiter_if -- terminal request/response bus plus account-memory port.
//   slave  : arbiter side (takes req*, mem_rdata; drives grant/done/resp*/mem_*)
//   master : terminals + memory side (the opposite directions)
interface atm_txn_arbiter_if;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_card;
  logic [63:0] req_amount;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  resp_status;
  logic [15:0] resp_balance;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] mem_wdata;

  modport slave (
    input  req, req_op, req_card, req_amount, mem_rdata,
    output grant, done, resp_status, resp_balance, mem_addr, mem_we, mem_wdata
  );
  modport master (
    output req, req_op, req_card, req_amount, mem_rdata,
    input  grant, done, resp_status, resp_balance, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter -- round-robin arbiter for 4 ATM terminals sharing one
// account memory. The winner's transaction walks status -> balance -> limit
// reads, then executes (balance / withdraw / deposit) and pulses done.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  atm_txn_arbiter_if.slave: req/req_op/req_card/req_amount in,
//        grant/done/resp_status/resp_balance out, mem_addr/mem_we/mem_wdata
//        out, mem_rdata in (valid one cycle after mem_addr).
// Build option: ATM_ARB_DAILY_LIMIT_EN adds the RD_LIM read and the withdraw
// limit check; without it RD_BAL goes straight to EXEC.
module atm_txn_arbiter (
  input logic             clk,
  input logic             rst,
  atm_txn_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_STAT, RD_BAL, RD_LIM, EXEC, RESP} state_e;

  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_CARD  = 8'h01;
  localparam logic [7:0] ST_FUNDS = 8'h03;
  localparam logic [7:0] ST_LIMIT = 8'h04;
  localparam logic [7:0] ST_OVF   = 8'h05;
  localparam logic [7:0] ST_OP    = 8'h06;

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  card_q, card_d;
  logic [15:0] amt_q, amt_d;
  logic [7:0]  rst_q, rst_d;   // resp_status register
  logic [15:0] rbal_q, rbal_d; // resp_balance register
`ifdef ATM_ARB_DAILY_LIMIT_EN
  logic [15:0] bal_q, bal_d;
`endif

  logic [7:0]  mem_addr_c;
  logic        mem_we_c;
  logic [15:0] mem_wdata_c;
  logic [3:0]  done_c;
  logic [1:0]  pick, cand;
  logic        found;
  logic [7:0]  base;
  logic [15:0] bal_v;
  logic [16:0] sum;

  always_comb begin
    state_d = state_q; grant_d = grant_q; owner_d = owner_q; last_d = last_q;
    op_d = op_q; card_d = card_q; amt_d = amt_q; rst_d = rst_q; rbal_d = rbal_q;
`ifdef ATM_ARB_DAILY_LIMIT_EN
    bal_d = bal_q;
    bal_v = bal_q;
`else
    bal_v = bus.mem_rdata;  // balance word arrives in EXEC when RD_LIM is absent
`endif
    mem_addr_c = 8'h00; mem_we_c = 1'b0; mem_wdata_c = 16'h0000; done_c = 4'b0000;
    base = {card_q[5:0], 2'b00};
    sum  = {1'b0, bal_v} + {1'b0, amt_q};
    // Round robin: scan last+1, last+2, ... last+4 (== last) and keep the first hit.
    found = 1'b0; pick = 2'd0; cand = 2'd0;
    for (int k = 1; k < 5; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    case (state_q)
      IDLE: if (found) begin
        grant_d = 4'b0001 << pick;
        owner_d = pick;
        op_d    = bus.req_op[2*pick +: 2];
        card_d  = bus.req_card[8*pick +: 8];
        amt_d   = bus.req_amount[16*pick +: 16];
        state_d = RD_STAT;
      end
      RD_STAT: if (card_q > 8'd8) begin
        rst_d = ST_CARD; rbal_d = 16'h0000; state_d = RESP;
      end else begin
        mem_addr_c = base + 8'd2;
        state_d    = RD_BAL;
      end
      RD_BAL: if (bus.mem_rdata != 16'h0001) begin
        rst_d = ST_CARD; rbal_d = 16'h0000; state_d = RESP;
      end else begin
        mem_addr_c = base + 8'd1;
`ifdef ATM_ARB_DAILY_LIMIT_EN
        state_d = RD_LIM;
`else
        state_d = EXEC;
`endif
      end
`ifdef ATM_ARB_DAILY_LIMIT_EN
      RD_LIM: begin
        bal_d      = bus.mem_rdata;
        mem_addr_c = base + 8'd3;
        state_d    = EXEC;
      end
`endif
      EXEC: begin
        // mem_rdata holds the limit word here when RD_LIM is built in.
        mem_addr_c = base + 8'd1;
        rbal_d     = bal_v;
        rst_d      = ST_OK;
        state_d    = RESP;
        case (op_q)
          2'b01: begin
`ifdef ATM_ARB_DAILY_LIMIT_EN
            if (amt_q > bus.mem_rdata) rst_d = ST_LIMIT;
            else
`endif
            if (amt_q > bal_v) rst_d = ST_FUNDS;
            else begin
              mem_we_c = 1'b1; mem_wdata_c = bal_v - amt_q; rbal_d = bal_v - amt_q;
            end
          end
          2'b10: if (sum[16]) rst_d = ST_OVF;
                 else begin
                   mem_we_c = 1'b1; mem_wdata_c = sum[15:0]; rbal_d = sum[15:0];
                 end
          2'b11: rst_d = ST_OP;
          default: ;
        endcase
      end
      RESP: begin
        done_c  = grant_q;
        grant_d = 4'b0000;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; grant_q <= 4'b0000; owner_q <= 2'd0; last_q <= 2'd3;
      op_q <= 2'd0; card_q <= 8'h00; amt_q <= 16'h0000;
      rst_q <= ST_OK; rbal_q <= 16'h0000;
`ifdef ATM_ARB_DAILY_LIMIT_EN
      bal_q <= 16'h0000;
`endif
    end else begin
      state_q <= state_d; grant_q <= grant_d; owner_q <= owner_d; last_q <= last_d;
      op_q <= op_d; card_q <= card_d; amt_q <= amt_d;
      rst_q <= rst_d; rbal_q <= rbal_d;
`ifdef ATM_ARB_DAILY_LIMIT_EN
      bal_q <= bal_d;
`endif
    end
  end

  // Memory strobes are decoded from state; rst masks them so a reset landing
  // on EXEC can never commit a write.
  assign bus.mem_addr     = rst ? 8'h00 : mem_addr_c;
  assign bus.mem_we       = mem_we_c & ~rst;
  assign bus.mem_wdata    = rst ? 16'h0000 : mem_wdata_c;
  assign bus.done         = rst ? 4'b0000 : done_c;
  assign bus.grant        = grant_q;
  assign bus.resp_status  = rst_q;
  assign bus.resp_balance = rbal_q;
endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Directed bench for atm_txn_arbiter: behavioural account memory, one linear
// stimulus sequence, immediate assertions at every comparison point.
module tb_atm_txn_arbiter;
`ifdef ATM_ARB_DAILY_LIMIT_EN
  localparam int VL = 5;
`else
  localparam int VL = 4;
`endif

  logic clk, rst;
  atm_txn_arbiter_if bus();
  atm_txn_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  // account memory: registered read, DUT writes, bench preload port
  logic [15:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_wa;
  logic [15:0] tb_wd;
  int          we_cnt = 0;
  logic [7:0]  last_waddr;
  logic [15:0] last_wdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      we_cnt     <= we_cnt + 1;
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    tb_wa = a; tb_wd = d; tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic run_txn(input string tag, input int term, input logic [1:0] op,
                         input logic [7:0] card, input logic [15:0] amt,
                         input int exp_dlat, input logic [7:0] exp_st,
                         input logic [15:0] exp_bal, input int exp_wr,
                         input logic [7:0] exp_waddr, input logic [15:0] exp_wdata,
                         input bit drop);
    int t0, w0, gl, dl;
    @(posedge clk); #1;
    bus.req_op[2*term +: 2]      = op;
    bus.req_card[8*term +: 8]    = card;
    bus.req_amount[16*term +: 16] = amt;
    bus.req[term]                = 1'b1;
    t0 = cyc; w0 = we_cnt;
    gl = -1;
    for (int i = 0; i < 20 && gl < 0; i++) begin
      @(negedge clk);
      if (bus.grant != 4'b0000) gl = cyc - t0;
    end
    chk({tag, "_grant_lat"}, gl, 1);
    chk({tag, "_grant"}, bus.grant, 32'(1) << term);
    if (drop) bus.req[term] = 1'b0;
    dl = -1;
    for (int i = 0; i < 20 && dl < 0; i++) begin
      @(negedge clk);
      if (bus.done != 4'b0000) dl = cyc - t0;
    end
    chk({tag, "_done_lat"}, dl, exp_dlat);
    chk({tag, "_done"}, bus.done, 32'(1) << term);
    chk({tag, "_status"}, bus.resp_status, exp_st);
    chk({tag, "_balance"}, bus.resp_balance, exp_bal);
    chk({tag, "_writes"}, we_cnt - w0, exp_wr);
    if (exp_wr != 0) begin
      chk({tag, "_waddr"}, last_waddr, exp_waddr);
      chk({tag, "_wdata"}, last_wdata, exp_wdata);
    end
    bus.req[term] = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 0);
    chk({tag, "_grant_clr"}, bus.grant, 0);
    chk({tag, "_status_hold"}, bus.resp_status, exp_st);
    chk({tag, "_balance_hold"}, bus.resp_balance, exp_bal);
  endtask

  initial begin
    int t0, w0, gl;
    bit seen;
    logic [3:0] exp_g;
    rst = 1'b1; tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 16'h0000;
    bus.req = 4'b0000; bus.req_op = '0; bus.req_card = '0; bus.req_amount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_status", bus.resp_status, 0);
    chk("rst_balance", bus.resp_balance, 0);

    // accounts: card2 ok 0x100 lim 0x80; card3 ok 0x50; card4 ok 0xFFF8;
    // card5 blocked; card8 ok 0x1234
    set_mem(8'd10, 16'h0001); set_mem(8'd9,  16'h0100); set_mem(8'd11, 16'h0080);
    set_mem(8'd14, 16'h0001); set_mem(8'd13, 16'h0050); set_mem(8'd15, 16'h0080);
    set_mem(8'd18, 16'h0001); set_mem(8'd17, 16'hFFF8); set_mem(8'd19, 16'hFFFF);
    set_mem(8'd22, 16'h0000);
    set_mem(8'd34, 16'h0001); set_mem(8'd33, 16'h1234); set_mem(8'd35, 16'hFFFF);
    @(posedge clk); #1; rst = 1'b0;

    run_txn("bal_t0", 0, 2'b00, 8'd2, 16'h0000, VL, 8'h00, 16'h0100, 0, 8'd0, 16'h0, 1'b0);
    run_txn("wd_ok", 1, 2'b01, 8'd2, 16'h0040, VL, 8'h00, 16'h00C0, 1, 8'd9, 16'h00C0, 1'b0);
    set_mem(8'd9, 16'h0100);
`ifdef ATM_ARB_DAILY_LIMIT_EN
    run_txn("wd_limit", 2, 2'b01, 8'd2, 16'h0090, VL, 8'h04, 16'h0100, 0, 8'd0, 16'h0, 1'b0);
`else
    run_txn("wd_nolimit", 2, 2'b01, 8'd2, 16'h0090, VL, 8'h00, 16'h0070, 1, 8'd9, 16'h0070, 1'b0);
`endif
    set_mem(8'd9, 16'h0100);
    run_txn("wd_funds", 3, 2'b01, 8'd3, 16'h0070, VL, 8'h03, 16'h0050, 0, 8'd0, 16'h0, 1'b0);
    run_txn("dep_ovf", 0, 2'b10, 8'd4, 16'h0010, VL, 8'h05, 16'hFFF8, 0, 8'd0, 16'h0, 1'b0);
    run_txn("dep_ok", 1, 2'b10, 8'd3, 16'h0010, VL, 8'h00, 16'h0060, 1, 8'd13, 16'h0060, 1'b0);
    run_txn("card9", 2, 2'b00, 8'd9, 16'h0000, 2, 8'h01, 16'h0000, 0, 8'd0, 16'h0, 1'b0);
    run_txn("blocked", 3, 2'b00, 8'd5, 16'h0000, 3, 8'h01, 16'h0000, 0, 8'd0, 16'h0, 1'b0);
    run_txn("bad_op", 0, 2'b11, 8'd2, 16'h0000, VL, 8'h06, 16'h0100, 0, 8'd0, 16'h0, 1'b0);
    run_txn("card8", 1, 2'b00, 8'd8, 16'h0000, VL, 8'h00, 16'h1234, 0, 8'd0, 16'h0, 1'b0);
    run_txn("drop_req", 2, 2'b01, 8'd2, 16'h0010, VL, 8'h00, 16'h00F0, 1, 8'd9, 16'h00F0, 1'b1);
    set_mem(8'd9, 16'h0100);

    // reset during cycle +3 of a withdraw (RD_LIM when the limit read is built in)
    @(posedge clk); #1;
    bus.req_op[3:2] = 2'b01; bus.req_card[15:8] = 8'd2; bus.req_amount[31:16] = 16'h0010;
    bus.req[1] = 1'b1; t0 = cyc; w0 = we_cnt;
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_cycle", cyc - t0, 3);
    chk("mid_rst_grant_before", bus.grant, 4'b0010);
    rst = 1'b1; bus.req = 4'b0000;
    @(negedge clk);
    chk("mid_rst_we", bus.mem_we, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", bus.grant, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done != 4'b0000) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 0);
    chk("mid_rst_no_write", we_cnt - w0, 0);
    chk("mid_rst_status", bus.resp_status, 0);

    // all four requesting from reset: 0,1,2,3,0 with done before each new grant
    @(posedge clk); #1;
    bus.req_op = 8'h00; bus.req_card = {4{8'd2}}; bus.req = 4'b1111;
    exp_g = 4'b0001;
    for (int n = 0; n < 5; n++) begin
      gl = -1;
      for (int i = 0; i < 20 && gl < 0; i++) begin
        @(negedge clk);
        if (bus.grant != 4'b0000) gl = i;
      end
      chk($sformatf("rr%0d_grant", n), bus.grant, exp_g);
      gl = -1;
      for (int i = 0; i < 20 && gl < 0; i++) begin
        @(negedge clk);
        if (bus.done != 4'b0000) gl = i;
      end
      chk($sformatf("rr%0d_done", n), bus.done, exp_g);
      @(negedge clk);
      chk($sformatf("rr%0d_gap", n), bus.grant, 0);
      exp_g = {exp_g[2:0], exp_g[3]};
    end
    bus.req = 4'b0000;
    repeat (8) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
